// File: rtl/hazard_stall_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_stall_unit                                          |
// | Description : FP pipeline scoreboard. Tracks in-flight destination       |
// |               registers, raises a decode hold on RAW hazards, and        |
// |               freezes the pipeline for the multi-cycle multiplier.       |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module hazard_stall_unit #(
  parameter int REG_AW   = 3,
  parameter int WB_DEPTH = 4,
  parameter int MUL_LAT  = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   issueValid,
  input  logic [REG_AW-1:0]      srcA,
  input  logic [REG_AW-1:0]      srcB,
  input  logic                   srcAEn,
  input  logic                   srcBEn,
  input  logic [REG_AW-1:0]      dst,
  input  logic                   dstWrEn,
  input  logic                   isMul,
  output logic                   stall,
  output logic                   hazStall,
  output logic                   issueAccept,
  output logic [(1<<REG_AW)-1:0] busyMask,
  output logic [15:0]            stallCount
);

  localparam int         c_NREG     = 1 << REG_AW;
  localparam logic [3:0] c_MUL_LOAD = 4'(MUL_LAT - 1);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } mulState_t;

  // Tracker: entry 0 is the youngest in-flight instruction.
  logic [WB_DEPTH-1:0] r_trkValid;
  logic [REG_AW-1:0]   r_trkDst [WB_DEPTH];

  mulState_t   r_state;
  mulState_t   w_stateNext;
  logic [3:0]  r_mulCnt;
  logic [3:0]  w_mulCntNext;
  logic        r_stall;
  logic [15:0] r_stallCount;
  logic [c_NREG-1:0] w_busyMask;

  assign stall       = r_stall;
  assign busyMask    = w_busyMask;
  assign stallCount  = r_stallCount;

  // No bypass network: any pending write to a read source holds decode.
  assign hazStall    = issueValid & ((srcAEn & w_busyMask[srcA]) |
                                     (srcBEn & w_busyMask[srcB]));
  assign issueAccept = issueValid & ~hazStall & ~r_stall;

  // Shift the tracker while the pipeline advances; hold it during a freeze.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_trkValid <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        r_trkDst[i] <= '0;
      end
    end else if (!r_stall) begin
      for (int i = WB_DEPTH - 1; i > 0; i--) begin
        r_trkValid[i] <= r_trkValid[i-1];
        r_trkDst[i]   <= r_trkDst[i-1];
      end
      // A bubble enters when nothing is issued or nothing is written.
      r_trkValid[0] <= issueAccept & dstWrEn;
      r_trkDst[0]   <= dst;
    end
  end

  // Decode valid tracker entries into a per-register pending-write mask.
  always_comb begin
    w_busyMask = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (r_trkValid[i]) begin
        w_busyMask[r_trkDst[i]] = 1'b1;
      end
    end
  end

  // Multiplier FSM state, countdown and registered freeze output.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= IDLE;
      r_mulCnt <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_mulCnt <= w_mulCntNext;
      r_stall  <= (w_stateNext == MUL_BUSY);
    end
  end

  // Next-state logic: MUL_BUSY lasts MUL_LAT cycles (counter MUL_LAT-1 .. 0).
  always_comb begin
    w_stateNext  = r_state;
    w_mulCntNext = r_mulCnt;
    case (r_state)
      IDLE: begin
        if (issueAccept && isMul) begin
          w_stateNext  = MUL_BUSY;
          w_mulCntNext = c_MUL_LOAD;
        end
      end
      MUL_BUSY: begin
        if (r_mulCnt == 4'd0) begin
          w_stateNext = IDLE;
        end else begin
          w_mulCntNext = r_mulCnt - 4'd1;
        end
      end
      default: begin
        w_stateNext  = IDLE;
        w_mulCntNext = '0;
      end
    endcase
  end

  // Saturating count of cycles lost to either freeze or decode hold.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_stallCount <= '0;
    end else if ((r_stall | hazStall) && (r_stallCount != 16'hFFFF)) begin
      r_stallCount <= r_stallCount + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hazard_stall_unit                                       |
// | Description : Directed self-checking bench for hazard_stall_unit.        |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_hazard_stall_unit;

  localparam int REG_AW   = 3;
  localparam int WB_DEPTH = 4;
  localparam int MUL_LAT  = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        issueValid = 1'b0;
  logic [2:0]  srcA = '0;
  logic [2:0]  srcB = '0;
  logic        srcAEn = 1'b0;
  logic        srcBEn = 1'b0;
  logic [2:0]  dst = '0;
  logic        dstWrEn = 1'b0;
  logic        isMul = 1'b0;
  logic        stall;
  logic        hazStall;
  logic        issueAccept;
  logic [7:0]  busyMask;
  logic [15:0] stallCount;

  hazard_stall_unit #(
    .REG_AW  (REG_AW),
    .WB_DEPTH(WB_DEPTH),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .issueValid (issueValid),
    .srcA       (srcA),
    .srcB       (srcB),
    .srcAEn     (srcAEn),
    .srcBEn     (srcBEn),
    .dst        (dst),
    .dstWrEn    (dstWrEn),
    .isMul      (isMul),
    .stall      (stall),
    .hazStall   (hazStall),
    .issueAccept(issueAccept),
    .busyMask   (busyMask),
    .stallCount (stallCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t        q[$];
  int          testCount = 0;
  int          failCount = 0;
  logic [15:0] expCnt = '0;

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      0:       return {31'd0, stall};
      1:       return {31'd0, hazStall};
      2:       return {31'd0, issueAccept};
      3:       return {24'd0, busyMask};
      default: return {16'd0, stallCount};
    endcase
  endfunction

  task automatic expectVal(input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic checkQueue();
    exp_t        e;
    logic [31:0] obs;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.sig);
      testCount++;
      assert (obs === e.val) else begin
        failCount++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Apply inputs mid-cycle, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [2:0] a, input logic aEn,
                       input logic [2:0] b, input logic bEn,
                       input logic [2:0] d, input logic dEn, input logic mul);
    @(negedge Clock);
    issueValid = v;
    srcA = a;  srcAEn = aEn;
    srcB = b;  srcBEn = bEn;
    dst  = d;  dstWrEn = dEn;
    isMul = mul;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  // Queue the expected outputs for this cycle, compare, then advance the count model.
  task automatic step(input string tag, input logic eStall, input logic eHaz,
                      input logic eAcc, input logic [7:0] eBusy);
    expectVal({tag, ".stall"},       0, {31'd0, eStall});
    expectVal({tag, ".hazStall"},    1, {31'd0, eHaz});
    expectVal({tag, ".issueAccept"}, 2, {31'd0, eAcc});
    expectVal({tag, ".busyMask"},    3, {24'd0, eBusy});
    expectVal({tag, ".stallCount"},  4, {16'd0, expCnt});
    checkQueue();
    if ((eStall | eHaz) && (expCnt != 16'hFFFF)) expCnt = expCnt + 16'd1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge Clock);
    #1;
    expectVal("reset.stall",      0, 32'd0);
    expectVal("reset.busyMask",   3, 32'd0);
    expectVal("reset.stallCount", 4, 32'd0);
    checkQueue();
    @(negedge Clock);
    Reset = 1'b1;

    // RAW: producer r3, consumer held for the full tracker depth
    drive(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0);  step("raw.prod", 0, 0, 1, 8'h00);
    for (int k = 0; k < WB_DEPTH; k++) begin
      drive(1, 3'd3, 1, 3'd0, 0, 3'd5, 0, 0); step("raw.wait", 0, 1, 0, 8'h08);
    end
    drive(1, 3'd3, 1, 3'd0, 0, 3'd5, 0, 0);  step("raw.issue", 0, 0, 1, 8'h00);

    // Unused sources do not block even when the register is busy
    drive(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0);  step("unused.prod", 0, 0, 1, 8'h00);
    drive(1, 3'd3, 0, 3'd3, 0, 3'd2, 1, 0);  step("unused.src", 0, 0, 1, 8'h08);
    for (int k = 0; k < 3; k++) begin
      idle(); step("unused.drain", 0, 0, 0, 8'h0C);
    end
    idle(); step("unused.r2only", 0, 0, 0, 8'h04);
    idle(); step("unused.empty", 0, 0, 0, 8'h00);

    // Multiply with a RAW-dependent (srcB) instruction presented during the freeze
    drive(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 1);  step("mul.issue", 0, 0, 1, 8'h00);
    for (int k = 0; k < MUL_LAT; k++) begin
      drive(1, 3'd0, 0, 3'd1, 1, 3'd0, 0, 0); step("mul.freeze", 1, 1, 0, 8'h02);
    end
    for (int k = 0; k < WB_DEPTH; k++) begin
      drive(1, 3'd0, 0, 3'd1, 1, 3'd0, 0, 0); step("mul.drain", 0, 1, 0, 8'h02);
    end
    drive(1, 3'd0, 0, 3'd1, 1, 3'd0, 0, 0);  step("mul.dep", 0, 0, 1, 8'h00);

    // A second multiply cannot issue while the first one is freezing the pipe
    drive(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 1);  step("mul2.issue", 0, 0, 1, 8'h00);
    for (int k = 0; k < MUL_LAT; k++) begin
      drive(1, 3'd0, 0, 3'd0, 0, 3'd7, 0, 1); step("mul2.blocked", 1, 0, 0, 8'h40);
    end
    drive(1, 3'd0, 0, 3'd0, 0, 3'd7, 0, 1);  step("mul2.next", 0, 0, 1, 8'h40);
    for (int k = 0; k < MUL_LAT; k++) begin
      idle(); step("mul3.freeze", 1, 0, 0, 8'h40);
    end
    for (int k = 0; k < 3; k++) begin
      idle(); step("mul3.drain", 0, 0, 0, 8'h40);
    end
    idle(); step("mul3.empty", 0, 0, 0, 8'h00);

    // Reset asserted mid-multiply clears everything without a clock edge
    drive(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 1);  step("rst.mul", 0, 0, 1, 8'h00);
    idle(); step("rst.frozen", 1, 0, 0, 8'h10);
    #3;
    Reset = 1'b0;
    #1;
    expectVal("rst.async.stall",      0, 32'd0);
    expectVal("rst.async.busyMask",   3, 32'd0);
    expectVal("rst.async.stallCount", 4, 32'd0);
    checkQueue();
    expCnt = '0;
    @(negedge Clock);
    Reset = 1'b1;
    idle(); step("rst.after", 0, 0, 0, 8'h00);
    idle(); step("rst.after", 0, 0, 0, 8'h00);
    drive(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 0);  step("rst.issue", 0, 0, 1, 8'h00);
    idle(); step("rst.noresid", 0, 0, 0, 8'h04);

    // Saturation: self-dependent multiplies keep the unit stalled most cycles
    for (int k = 0; k < 74000; k++) begin
      drive(1, 3'd3, 1, 3'd0, 0, 3'd3, 1, 1);
    end
    expectVal("sat.count", 4, 32'h0000FFFF);
    checkQueue();
    for (int k = 0; k < 20; k++) begin
      drive(1, 3'd3, 1, 3'd0, 0, 3'd3, 1, 1);
    end
    expectVal("sat.nowrap", 4, 32'h0000FFFF);
    checkQueue();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
`default_nettype wire
